glyph_fetch_sched: RTL and testbench
====================================

Name: glyph_fetch_sched

Overview:
Sequences packet reads from the character-data async FIFO into a double-buffered glyph store for the HDMI overlay. A packet is fixed at 2**IDX_W 128-bit words. A burst starts only when a whole packet is buffered. Words are lane-reordered and written into the back bank. The completed bank is swapped to display on the next frame-start pulse, so a half-loaded glyph set is never displayed.

Parameters:
IDX_W, 5, log2 of words per packet (packet = 32 words)
WL_W, 8, width of fifo_waterlevel
RD_LAT, 1, FIFO read latency in clk cycles (rd_en to valid data), 1..3
LANE_SWAP, 1, 1 = reverse the four 32-bit lanes of each word; 0 = pass through

Ports:
clk  in  1  system clock
rstn  in  1  reset
enable  in  1  allow new bursts to start
flush  in  1  one-cycle abort of the current packet
vs_pulse  in  1  one-cycle frame-start strobe, clk domain
fifo_waterlevel  in  WL_W  FIFO read-side fill count
fifo_rd_data  in  128  FIFO read data
fifo_rd_en  out  1  FIFO read strobe
buf_we  out  1  glyph store write enable
buf_wbank  out  1  bank being written (always equals ~disp_bank)
buf_widx  out  IDX_W  word index within the packet
buf_wdata  out  128  reordered write data
disp_bank  out  1  bank selected for display
pkt_done  out  1  one-cycle pulse when the last word of a packet is written
swap_pulse  out  1  one-cycle pulse when disp_bank toggles
busy  out  1  high from burst start until commit or flush completion
pkt_count  out  16  count of completed packets, wraps at 65535 to 0

Behaviour:
- Reset is asynchronous and active-low on rstn; clock is clk. All outputs reset to 0; state IDLE; pending_swap=0.
- States:
  - IDLE: go to BURST when enable=1, pending_swap=0, fifo_waterlevel >= 2**IDX_W and flush=0.
  - BURST: fifo_rd_en=1 for exactly 2**IDX_W consecutive cycles, counted by an internal counter of IDX_W+1 bits. Go to DRAIN after the last read.
  - DRAIN: wait until all in-flight words are written (RD_LAT+1 cycles after the last rd_en). Then go to COMMIT.
  - COMMIT: one cycle. Set pending_swap=1, increment pkt_count, return to IDLE.
- Data path:
  - rd_en is delayed through an RD_LAT-deep valid shift register.
  - When the tap is high, fifo_rd_data is registered into buf_wdata. With LANE_SWAP=1 the order is {d[31:0],d[63:32],d[95:64],d[127:96]}.
  - buf_we asserts the following cycle. A word read at cycle t therefore appears as buf_we at t+RD_LAT+1.
  - buf_widx starts at 0 for each packet and increments after each buf_we.
  - pkt_done is asserted in the same cycle as the buf_we for widx = 2**IDX_W-1.
- Bank swap:
  - On vs_pulse with pending_swap=1 (registered value): disp_bank toggles, swap_pulse=1, pending_swap clears, all in the same cycle.
  - A commit in the same cycle as vs_pulse does not swap on that pulse; it swaps on the next one.
  - vs_pulse with pending_swap=0 has no effect.
- Back-pressure: while pending_swap=1, no new burst starts, even if the FIFO is full. At most one completed-but-undisplayed packet exists.
- enable deasserted mid-burst: the packet completes (bursts are atomic); only new starts are blocked.
- fifo_waterlevel falling mid-burst: ignored. Upstream guarantees no underflow.
- flush:
  - In BURST, fifo_rd_en drops the next cycle.
  - In-flight words are still popped but buf_we is suppressed.
  - State goes to IDLE once the valid pipeline is empty; buf_widx goes to 0.
  - pkt_done, pending_swap and pkt_count are unchanged; the back-bank contents are undefined.
  - flush in IDLE or COMMIT: ignored (COMMIT completes).
- flush and vs_pulse in the same cycle: both are honoured independently.
- busy = state != IDLE, or the valid pipeline is non-empty.
- Reset mid-burst: everything returns to reset values immediately, including disp_bank=0. The FIFO is not re-aligned by this block; the system resets the FIFO together with this block.

Test Plan:
- Waterlevel 31 held 100 cycles, enable=1 -> no fifo_rd_en. Raise to 32 -> rd_en high for exactly 32 cycles. buf_we for widx 0..31 starts RD_LAT+1 cycles after the first rd_en. pkt_done on widx 31. pkt_count=1. buf_wbank=1.
- Word 0x00000003_00000002_00000001_00000000 with LANE_SWAP=1 -> buf_wdata=0x00000000_00000001_00000002_00000003. With LANE_SWAP=0 -> unchanged.
- Packet committed, waterlevel 64, no vs_pulse for 500 cycles -> no second burst. vs_pulse -> disp_bank=1 and swap_pulse the same cycle. Second burst starts within 2 cycles and writes bank 0.
- COMMIT coincident with vs_pulse -> no swap on that pulse; swap on the next vs_pulse.
- flush at the 10th rd_en cycle (RD_LAT=2) -> rd_en low next cycle, no buf_we after flush, no pkt_done, pkt_count unchanged. The next full packet writes widx 0..31 correctly.
- rstn low mid-burst (widx=17) -> all outputs 0 asynchronously. After release with waterlevel>=32, a normal burst runs from widx 0.

Source files
------------

// File: rtl/glyph_fetch_sched.sv
// Glyph fetch scheduler: pulls whole packets from the character FIFO into the
// back bank of a double-buffered glyph store and swaps banks on frame start.
module glyph_fetch_sched #(
    parameter int IDX_W     = 5,
    parameter int WL_W      = 8,
    parameter int RD_LAT    = 1,
    parameter int LANE_SWAP = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              enable,
    input  logic              flush,
    input  logic              vs_pulse,
    input  logic [WL_W-1:0]   fifo_waterlevel,
    input  logic [127:0]      fifo_rd_data,
    output logic              fifo_rd_en,
    output logic              buf_we,
    output logic              buf_wbank,
    output logic [IDX_W-1:0]  buf_widx,
    output logic [127:0]      buf_wdata,
    output logic              disp_bank,
    output logic              pkt_done,
    output logic              swap_pulse,
    output logic              busy,
    output logic [15:0]       pkt_count
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_BURST  = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_COMMIT = 2'd3;

    localparam int              PKT      = 2 ** IDX_W;
    localparam logic [IDX_W:0]  LAST_RD  = (IDX_W + 1)'(PKT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT - 1);

    logic [1:0]        state_q, state_d;
    logic [IDX_W:0]    rd_cnt_q, rd_cnt_d;
    logic [RD_LAT-1:0] vpipe_q, vpipe_d;
    logic              flushing_q, flushing_d;
    logic              we_q, we_d;
    logic [127:0]      wdata_q, wdata_d;
    logic [IDX_W-1:0]  widx_q, widx_d;
    logic              bank_q, bank_d;
    logic              pend_q, pend_d;
    logic              swap_q, swap_d;
    logic [15:0]       cnt_q, cnt_d;

    logic         rd_en;
    logic         tap;
    logic         pipe_empty;
    logic         abort;
    logic         flush_exit;
    logic [127:0] lanes;

    assign rd_en      = (state_q == S_BURST);
    assign tap        = vpipe_q[RD_LAT-1];
    assign pipe_empty = (vpipe_q == '0);
    assign abort      = flush | flushing_q;
    assign flush_exit = (state_q == S_DRAIN) && pipe_empty && abort;

    assign lanes = (LANE_SWAP != 0)
                 ? {fifo_rd_data[31:0], fifo_rd_data[63:32],
                    fifo_rd_data[95:64], fifo_rd_data[127:96]}
                 : fifo_rd_data;

    always_comb begin
        state_d    = state_q;
        rd_cnt_d   = rd_cnt_q;
        flushing_d = flushing_q;
        case (state_q)
            S_IDLE: begin
                rd_cnt_d   = '0;
                flushing_d = 1'b0;
                if (enable && !pend_q && !flush &&
                    32'(fifo_waterlevel) >= PKT)
                    state_d = S_BURST;
            end
            S_BURST: begin
                rd_cnt_d = rd_cnt_q + (IDX_W + 1)'(1);
                if (flush) begin
                    flushing_d = 1'b1;
                    state_d    = S_DRAIN;
                end else if (rd_cnt_q == LAST_RD) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (flush)
                    flushing_d = 1'b1;
                if (pipe_empty) begin
                    state_d    = abort ? S_IDLE : S_COMMIT;
                    flushing_d = 1'b0;
                end
            end
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Flushed words are still popped from the FIFO but never written.
    always_comb begin
        vpipe_d    = '0;
        vpipe_d[0] = rd_en;
        for (int i = 1; i < RD_LAT; i++)
            vpipe_d[i] = vpipe_q[i-1];
        we_d    = tap && !abort;
        wdata_d = tap ? lanes : wdata_q;
        widx_d  = widx_q;
        if (flush_exit)
            widx_d = '0;
        else if (we_q)
            widx_d = widx_q + IDX_W'(1);
    end

    // A commit sets pending only after the swap decision, so a coincident
    // frame pulse leaves the new bank for the following frame.
    always_comb begin
        pend_d = pend_q;
        bank_d = bank_q;
        swap_d = 1'b0;
        cnt_d  = cnt_q;
        if (vs_pulse && pend_q) begin
            bank_d = ~bank_q;
            swap_d = 1'b1;
            pend_d = 1'b0;
        end
        if (state_q == S_COMMIT) begin
            pend_d = 1'b1;
            cnt_d  = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            rd_cnt_q   <= '0;
            vpipe_q    <= '0;
            flushing_q <= 1'b0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            widx_q     <= '0;
            bank_q     <= 1'b0;
            pend_q     <= 1'b0;
            swap_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            rd_cnt_q   <= rd_cnt_d;
            vpipe_q    <= vpipe_d;
            flushing_q <= flushing_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            widx_q     <= widx_d;
            bank_q     <= bank_d;
            pend_q     <= pend_d;
            swap_q     <= swap_d;
            cnt_q      <= cnt_d;
        end
    end

    assign fifo_rd_en = rd_en;
    assign buf_we     = we_q;
    assign buf_wbank  = ~bank_q;
    assign buf_widx   = widx_q;
    assign buf_wdata  = wdata_q;
    assign disp_bank  = bank_q;
    assign pkt_done   = we_q && (widx_q == LAST_IDX);
    assign swap_pulse = swap_q;
    assign busy       = (state_q != S_IDLE) || !pipe_empty;
    assign pkt_count  = cnt_q;

endmodule

// File: tb/tb_glyph_fetch_sched.sv
// Directed bench for glyph_fetch_sched: burst gating, lane order, bank
// swap timing, flush and asynchronous reset.
module tb_glyph_fetch_sched;

    localparam int IDX_W  = 5;
    localparam int WL_W   = 8;
    localparam int RD_LAT = 2;
    localparam int PKT    = 32;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            enable = 1'b0;
    logic            flush = 1'b0;
    logic            vs_pulse = 1'b0;
    logic [WL_W-1:0] wl = '0;
    logic [127:0]    rd_data;
    logic [127:0]    d1 = '0;
    logic [127:0]    d2 = '0;

    logic             rd_en, we, wbank, disp_bank, pkt_done, swap_pulse, busy;
    logic [IDX_W-1:0] widx;
    logic [127:0]     wdata;
    logic [15:0]      pkt_count;

    logic             n_rd_en, n_we, n_wbank, n_disp, n_done, n_swap, n_busy;
    logic [IDX_W-1:0] n_widx;
    logic [127:0]     n_wdata;
    logic [15:0]      n_cnt;

    glyph_fetch_sched #(
        .IDX_W(IDX_W), .WL_W(WL_W), .RD_LAT(RD_LAT), .LANE_SWAP(1)
    ) u_dut (
        .clk(clk), .rstn(rstn), .enable(enable), .flush(flush),
        .vs_pulse(vs_pulse), .fifo_waterlevel(wl),
        .fifo_rd_data(rd_data), .fifo_rd_en(rd_en),
        .buf_we(we), .buf_wbank(wbank), .buf_widx(widx),
        .buf_wdata(wdata), .disp_bank(disp_bank), .pkt_done(pkt_done),
        .swap_pulse(swap_pulse), .busy(busy), .pkt_count(pkt_count)
    );

    glyph_fetch_sched #(
        .IDX_W(IDX_W), .WL_W(WL_W), .RD_LAT(RD_LAT), .LANE_SWAP(0)
    ) u_ns (
        .clk(clk), .rstn(rstn), .enable(enable), .flush(flush),
        .vs_pulse(vs_pulse), .fifo_waterlevel(wl),
        .fifo_rd_data(rd_data), .fifo_rd_en(n_rd_en),
        .buf_we(n_we), .buf_wbank(n_wbank), .buf_widx(n_widx),
        .buf_wdata(n_wdata), .disp_bank(n_disp), .pkt_done(n_done),
        .swap_pulse(n_swap), .busy(n_busy), .pkt_count(n_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] word(input int unsigned k);
        word = {32'(4*k+3), 32'(4*k+2), 32'(4*k+1), 32'(4*k)};
    endfunction

    function automatic logic [127:0] lsw(input logic [127:0] d);
        lsw = {d[31:0], d[63:32], d[95:64], d[127:96]};
    endfunction

    // FIFO model with two-cycle read latency
    int unsigned fifo_k = 0;
    always @(posedge clk) begin
        if (rd_en) begin
            d1     <= word(fifo_k);
            fifo_k <= fifo_k + 1;
        end else begin
            d1 <= '0;
        end
        d2 <= d1;
    end
    assign rd_data = d2;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    int          cyc = 0;
    logic        rd_prev = 1'b0;
    int          run = 0, last_run = 0, rd_total = 0;
    int unsigned base = 0;
    int          exp_widx = 0, pkt_wr = 0, done_cnt = 0;
    int          first_rd_cyc = 0, lat = 0;
    logic        last_wbank = 1'b0;
    logic        no_we = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rd_en && !rd_prev) begin
            base         = fifo_k;
            exp_widx     = 0;
            pkt_wr       = 0;
            first_rd_cyc = cyc;
            run          = 0;
        end
        if (rd_en) begin
            run++;
            rd_total++;
        end else if (rd_prev) begin
            last_run = run;
        end
        rd_prev = rd_en;
        if (we) begin
            if (exp_widx == 0) lat = cyc - first_rd_cyc;
            check("widx", 128'(widx), 128'(exp_widx));
            check("wdata", wdata, lsw(word(base + exp_widx)));
            check("wdata_noswap", n_wdata, word(base + exp_widx));
            check("wbank", 128'(wbank), 128'(!disp_bank));
            check("pkt_done", 128'(pkt_done), 128'(exp_widx == PKT-1));
            last_wbank = wbank;
            exp_widx++;
            pkt_wr++;
        end
        if (pkt_done) done_cnt++;
        if (no_we) check("no_we_flush", 128'(we), 128'(0));
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_rd(input int lim, input string tag);
        for (int i = 0; i < lim && !rd_en; i++) step();
        check(tag, 128'(rd_en), 128'(1));
    endtask

    task automatic wait_cnt(input logic [15:0] tgt, input int lim,
                            input string tag);
        for (int i = 0; i < lim && pkt_count != tgt; i++) step();
        check(tag, 128'(pkt_count), 128'(tgt));
    endtask

    task automatic pulse_vs();
        vs_pulse = 1'b1;
        step();
        vs_pulse = 1'b0;
    endtask

    int r0;
    int d0;

    initial begin
        step(3);
        check("rst_rd_en", 128'(rd_en), 128'(0));
        check("rst_we", 128'(we), 128'(0));
        check("rst_disp", 128'(disp_bank), 128'(0));
        check("rst_count", 128'(pkt_count), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_wdata", wdata, 128'(0));
        @(negedge clk) rstn = 1'b1;

        // below-threshold waterlevel, plus a pulse with nothing pending
        enable = 1'b1;
        wl     = 8'd31;
        r0     = rd_total;
        step(100);
        pulse_vs();
        check("vs_nopend_bank", 128'(disp_bank), 128'(0));
        check("vs_nopend_swap", 128'(swap_pulse), 128'(0));
        check("wl31_no_rd", 128'(rd_total - r0), 128'(0));

        wl = 8'd32;
        wait_rd(10, "burst1_start");
        wait_cnt(16'd1, 200, "pkt1_count");
        check("burst1_len", 128'(last_run), 128'(PKT));
        check("pkt1_writes", 128'(pkt_wr), 128'(PKT));
        check("pkt1_lat", 128'(lat), 128'(RD_LAT + 1));
        check("pkt1_done", 128'(done_cnt), 128'(1));
        check("pkt1_wbank", 128'(last_wbank), 128'(1));

        // pending swap holds off the next burst
        wl = 8'd64;
        r0 = rd_total;
        step(500);
        check("pend_no_rd", 128'(rd_total - r0), 128'(0));
        check("pend_busy", 128'(busy), 128'(0));
        pulse_vs();
        check("swap1_bank", 128'(disp_bank), 128'(1));
        check("swap1_pulse", 128'(swap_pulse), 128'(1));
        wait_rd(2, "burst2_start");
        check("swap1_pulse_end", 128'(swap_pulse), 128'(0));
        wait_cnt(16'd2, 200, "pkt2_count");
        check("pkt2_writes", 128'(pkt_wr), 128'(PKT));
        check("pkt2_wbank", 128'(last_wbank), 128'(0));

        // frame pulse coinciding with COMMIT
        pulse_vs();
        check("swap2_bank", 128'(disp_bank), 128'(0));
        for (int i = 0; i < 100 && !pkt_done; i++) step();
        check("pkt3_done_seen", 128'(pkt_done), 128'(1));
        step();
        pulse_vs();
        check("commit_vs_swap", 128'(swap_pulse), 128'(0));
        check("commit_vs_bank", 128'(disp_bank), 128'(0));
        check("pkt3_count", 128'(pkt_count), 128'(3));
        step(5);
        check("pend3_no_rd", 128'(rd_en), 128'(0));
        pulse_vs();
        check("swap3_bank", 128'(disp_bank), 128'(1));
        check("swap3_pulse", 128'(swap_pulse), 128'(1));

        // flush on the 10th read of the next burst
        wait_rd(3, "burst4_start");
        d0 = done_cnt;
        step(9);
        check("flush_rd_before", 128'(rd_en), 128'(1));
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_rd_drop", 128'(rd_en), 128'(0));
        no_we = 1'b1;
        for (int i = 0; i < 20 && busy; i++) step();
        check("flush_idle", 128'(busy), 128'(0));
        no_we = 1'b0;
        check("flush_widx", 128'(widx), 128'(0));
        check("flush_count", 128'(pkt_count), 128'(3));
        check("flush_done", 128'(done_cnt), 128'(d0));
        check("flush_len", 128'(last_run), 128'(10));
        wait_cnt(16'd4, 200, "pkt5_count");
        check("pkt5_writes", 128'(pkt_wr), 128'(PKT));
        check("pkt5_done", 128'(done_cnt), 128'(d0 + 1));

        // asynchronous reset in the middle of a burst
        pulse_vs();
        for (int i = 0; i < 100 && !(we && widx == 5'd17); i++) step();
        check("rst_mid_found", 128'(we && widx == 5'd17), 128'(1));
        #1 rstn = 1'b0;
        #1;
        check("rstm_rd_en", 128'(rd_en), 128'(0));
        check("rstm_we", 128'(we), 128'(0));
        check("rstm_widx", 128'(widx), 128'(0));
        check("rstm_wdata", wdata, 128'(0));
        check("rstm_disp", 128'(disp_bank), 128'(0));
        check("rstm_count", 128'(pkt_count), 128'(0));
        check("rstm_busy", 128'(busy), 128'(0));
        check("rstm_done", 128'(pkt_done), 128'(0));
        step(2);
        @(negedge clk) rstn = 1'b1;
        wait_cnt(16'd1, 200, "post_rst_count");
        check("post_rst_writes", 128'(pkt_wr), 128'(PKT));
        check("post_rst_wbank", 128'(last_wbank), 128'(1));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
